// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } state_t;

  localparam int unsigned PC_STEP          = 4;
  localparam int unsigned DEFAULT_RESET_PC = 0;

  // Entry fields are sized for the widest supported instruction/address (32 bits);
  // narrower instances zero-extend on push and slice on pop.
  localparam int unsigned ENTRY_DATA_W = 32;
  localparam int unsigned ENTRY_ADDR_W = 32;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic [ENTRY_ADDR_W-1:0] pc;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer; flush wins over push and is applied after any pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = CNT_W - 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues fixed-latency imem reads and buffers
// returned instructions for decode; a redirect flushes buffered and in-flight work.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned       CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_addr;
  logic              inflight;
  logic              grant;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              push;
  logic              pop;
  entry_t            wr_entry;
  entry_t            head_entry;
  logic              unused_bits;

  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign grant     = imem_req && imem_gnt;
  assign imem_addr = pc;

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH: begin
        state_next = FETCH;
        imem_req   = !redirect_valid && (occupancy < (CNT_W + 1)'(DEPTH));
      end
      FLUSH:   state_next = FETCH;
      default: state_next = IDLE;
    endcase
    if (redirect_valid) begin
      state_next = FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= PC_RST;
      inflight      <= 1'b0;
      inflight_addr <= PC_RST;
    end else begin
      state    <= state_next;
      inflight <= grant;
      if (grant) begin
        inflight_addr <= pc;
      end
      if (redirect_valid) begin
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (grant) begin
        pc <= pc + ADDR_W'(PC_STEP);
      end
    end
  end

  // The response slot is discarded during FLUSH and on the redirect cycle itself.
  assign push          = inflight && (state != FLUSH) && !redirect_valid;
  assign pop           = inst_valid && inst_ready;
  assign wr_entry.data = ENTRY_DATA_W'(imem_rdata);
  assign wr_entry.pc   = ENTRY_ADDR_W'(inflight_addr);

  fetch_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .wr_data(wr_entry),
    .head   (head_entry),
    .count  (count)
  );

  assign inst_valid  = (count != '0);
  assign inst_data   = head_entry.data[DATA_W-1:0];
  assign inst_pc     = head_entry.pc[ADDR_W-1:0];
  assign unused_bits = ^{head_entry, redirect_pc[1:0]};

endmodule
